// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - command-driven controller sequencing a WIDTH-bit modulo counter
// Accepts single-cycle host commands; provides free-run up/down, one-shot, load, clear and modulus.
module counter_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ONESHOT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_SET_MOD    = 3'd1;
    localparam logic [2:0] OP_LOAD       = 3'd2;
    localparam logic [2:0] OP_START_UP   = 3'd3;
    localparam logic [2:0] OP_START_DOWN = 3'd4;
    localparam logic [2:0] OP_STOP       = 3'd5;
    localparam logic [2:0] OP_ONESHOT    = 3'd6;
    localparam logic [2:0] OP_CLEAR      = 3'd7;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] max_q,   max_d;
    logic             dir_up_q, dir_up_d;
    logic             tc_q,    tc_d;
    logic             done_q,  done_d;

    logic             cmd_fire;
    logic             run_step;
    logic             at_max;
    logic             at_zero;

    assign cmd_ready = (state_q != ST_ONESHOT);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign at_max    = (count_q == max_q);
    assign at_zero   = (count_q == '0);

    // Any accepted non-NOP command suppresses the free-run step on that edge.
    assign run_step  = (state_q == ST_RUN) && (!cmd_fire || (cmd_op == OP_NOP));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        max_d    = max_q;
        dir_up_d = dir_up_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        if (cmd_fire) begin
            done_d = 1'b0;
            case (cmd_op)
                OP_SET_MOD: begin
                    max_d = cmd_data;
                    if (count_q > cmd_data) begin
                        count_d = cmd_data;
                    end
                end
                OP_LOAD: begin
                    count_d = (cmd_data > max_q) ? max_q : cmd_data;
                end
                OP_START_UP: begin
                    dir_up_d = 1'b1;
                    state_d  = ST_RUN;
                end
                OP_START_DOWN: begin
                    dir_up_d = 1'b0;
                    state_d  = ST_RUN;
                end
                OP_STOP: begin
                    state_d = ST_IDLE;
                end
                OP_ONESHOT: begin
                    state_d = ST_ONESHOT;
                end
                OP_CLEAR: begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                end
            endcase
        end

        if (run_step) begin
            if (dir_up_q) begin
                if (at_max) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    count_d = max_q;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end

        // One-shot never wraps, so it never raises tc; commands are blocked while it runs.
        if (state_q == ST_ONESHOT) begin
            if (at_max) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            max_q    <= '1;
            dir_up_q <= 1'b1;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            max_q    <= max_d;
            dir_up_q <= dir_up_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_ONESHOT);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - self-checking bench for counter_seq_ctrl against a behavioural model
module tb_counter_seq_ctrl;

    localparam int W    = 3;
    localparam int FULL = (1 << W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OS   = 2;
    localparam int M_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count     (count),
        .tc        (tc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_count, m_max, m_up, m_mode, m_tc, m_done;
    bit m_valid = 1'b0;
    bit m_acc, m_stepping;
    int m_op, m_d;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: modulo arithmetic over a (max+1)-sized ring.
    always @(posedge clk) begin
        if (rst) begin
            m_count = 0; m_max = FULL; m_up = 1; m_mode = M_IDLE;
            m_tc = 0; m_done = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_acc = cmd_valid && (m_mode != M_OS);
            m_op  = int'(cmd_op);
            m_d   = int'(cmd_data);
            m_stepping = (m_mode == M_RUN) && (!m_acc || m_op == 0);
            m_tc = 0;
            if (m_stepping) begin
                if (m_up != 0) begin
                    m_count = (m_count + 1) % (m_max + 1);
                    m_tc = (m_count == 0);
                end else begin
                    m_count = (m_count + m_max) % (m_max + 1);
                    m_tc = (m_count == m_max);
                end
            end else if (m_mode == M_OS) begin
                if (m_count == m_max) begin
                    m_mode = M_DONE; m_done = 1;
                end else begin
                    m_count = m_count + 1;
                end
            end
            if (m_acc) begin
                m_done = 0;
                case (m_op)
                    1: begin m_max = m_d; if (m_count > m_d) m_count = m_d; end
                    2: m_count = (m_d < m_max) ? m_d : m_max;
                    3: begin m_up = 1; m_mode = M_RUN; end
                    4: begin m_up = 0; m_mode = M_RUN; end
                    5: m_mode = M_IDLE;
                    6: m_mode = M_OS;
                    7: begin m_count = 0; m_mode = M_IDLE; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_count", int'(count), m_count);
            chk("cmp_tc", int'(tc), m_tc);
            chk("cmp_busy", int'(busy), int'(m_mode == M_RUN || m_mode == M_OS));
            chk("cmp_done", int'(done), m_done);
            chk("cmp_ready", int'(cmd_ready), int'(m_mode != M_OS));
        end
    end

    task automatic send(input int op, input int d);
        bit acc;
        cmd_valid = 1'b1;
        cmd_op    = op[2:0];
        cmd_data  = d[W-1:0];
        for (int k = 0; k < 50; k++) begin
            acc = (m_mode != M_OS);
            @(negedge clk);
            if (acc) begin
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout: op %0d not accepted within 50 cycles", op);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        step(2);
        chk("rst_count", int'(count), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        rst = 1'b0;

        send(3, 0);
        chk("up_start", int'(count), 0);
        step(7);
        chk("up_7", int'(count), 7);
        step(1);
        chk("up_wrap", int'(count), 0);
        chk("up_wrap_tc", int'(tc), 1);

        send(1, 4);
        send(3, 0);
        chk("mod5_hold", int'(count), 0);
        step(4);
        chk("mod5_4", int'(count), 4);
        step(1);
        chk("mod5_wrap", int'(count), 0);
        chk("mod5_tc", int'(tc), 1);
        step(2);
        send(5, 0);
        chk("stop_count", int'(count), 2);
        chk("stop_busy", int'(busy), 0);

        send(2, 2);
        send(4, 0);
        step(2);
        chk("down_0", int'(count), 0);
        chk("down_0_tc", int'(tc), 0);
        step(1);
        chk("down_wrap", int'(count), 4);
        chk("down_wrap_tc", int'(tc), 1);
        step(1);
        send(3, 0);
        chk("reverse_hold", int'(count), 3);
        step(1);
        chk("reverse_up", int'(count), 4);

        send(5, 0);
        send(2, 7);
        chk("load_clamp", int'(count), 4);
        send(1, 2);
        chk("setmod_clamp", int'(count), 2);
        send(1, 0);
        send(3, 0);
        step(2);
        chk("max0_count", int'(count), 0);
        chk("max0_tc", int'(tc), 1);

        send(7, 0);
        send(1, 5);
        send(2, 1);
        send(6, 0);
        chk("os_ready", int'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        step(4);
        chk("os_count5", int'(count), 5);
        chk("os_busy", int'(busy), 1);
        step(1);
        chk("os_done", int'(done), 1);
        chk("os_done_busy", int'(busy), 0);
        chk("os_done_ready", int'(cmd_ready), 1);
        step(1);
        cmd_valid = 1'b0;
        chk("os_stop_clears_done", int'(done), 0);
        send(7, 0);
        chk("clear_count", int'(count), 0);

        send(1, 6);
        send(2, 1);
        send(6, 0);
        step(2);
        chk("os_mid_count", int'(count), 3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        send(3, 0);
        step(7);
        chk("mid_rst_max7", int'(count), 7);

        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 249) == 0);
            cmd_valid = ($urandom_range(0, 9) < 4);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, FULL))
                                                     : W'($urandom_range(0, 3));
            @(negedge clk);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
